// File: rtl/pixel_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_pkg
// Description : Shared constants and state encoding for the pixel stream
//               transmitter, the edge-detection filter and their benches.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_stream_pkg;

  localparam int PIX_W     = 8;
  localparam int DEFAULT_N = 450;
  localparam int DEFAULT_M = 450;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PRIME  = 2'b01,
    ST_STREAM = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_frame_ram.sv
`default_nettype none
// ============================================================================
// Module      : pixel_frame_ram
// Description : Single-port frame store, synchronous read with one cycle of
//               latency, write-first. The read register returns zero on
//               cycles with no read so it can drive the pixel output directly.
//               Contents are never cleared; only the read register resets.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_frame_ram
  import pixel_stream_pkg::*;
#(
  parameter int DEPTH = DEFAULT_N * DEFAULT_M,
  parameter int AW    = $clog2(DEFAULT_N * DEFAULT_M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rdata_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [IW-1:0]    w_idx;

  assign w_idx = addr_i[IW-1:0];

  // Storage array: written only by the host port, never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[w_idx] <= wdata_i;
    end
  end

  // Read register: write-first on a same-cycle access, zero when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= we_i ? wdata_i : mem_q[w_idx];
    end else begin
      rdata_o <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_tx
// Description : Frame-buffered pixel transmitter. The host loads an N x M
//               greyscale frame while idle; on start the frame is replayed in
//               raster order as one gap-free data_valid burst with sof/eol/eof
//               markers, followed by a one-cycle frame_done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_tx
  import pixel_stream_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int M  = DEFAULT_M,
  parameter int AW = $clog2(N * M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             start,
  output logic             data_valid,
  output logic [PIX_W-1:0] Dout,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       frame_cnt,
  output logic             wr_err
);

  localparam int NPIX = N * M;
  localparam int RW   = (N > 1) ? $clog2(N) : 1;
  localparam int CW   = (M > 1) ? $clog2(M) : 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(N - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(M - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          valid_q, valid_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          w_ram_we;
  logic          w_ram_re;
  logic [AW-1:0] w_ram_addr;
  logic          w_wr_in_range;

  assign w_wr_in_range = (32'(wr_addr) < NPIX);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      row_q     <= row_d;
      col_q     <= col_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic. The row/col counters name the pixel that the next
  // edge will present, so every marker is computed one cycle early and
  // registered alongside the RAM read of the same pixel.
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    row_d      = row_q;
    col_d      = col_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eol_d      = 1'b0;
    eof_d      = 1'b0;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    err_d      = err_q;
    w_ram_we   = 1'b0;
    w_ram_re   = 1'b0;
    w_ram_addr = rd_addr_q;

    case (state_q)
      ST_IDLE: begin
        // Host owns the RAM port; a write in the start cycle lands before
        // PRIME reads address 0, so it is part of the frame.
        w_ram_addr = wr_addr;
        w_ram_we   = wr_en && w_wr_in_range;
        rd_addr_d  = '0;
        row_d      = '0;
        col_d      = '0;
        if (start) begin
          state_d = ST_PRIME;
          err_d   = 1'b0;
        end
      end

      ST_PRIME, ST_STREAM: begin
        if (wr_en) begin
          err_d = 1'b1;
        end
        if ((state_q == ST_STREAM) && eof_q) begin
          // Last pixel is on the output now; no further read is issued.
          state_d = ST_DONE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          state_d  = ST_STREAM;
          w_ram_re = 1'b1;
          valid_d  = 1'b1;
          sof_d    = (row_q == '0) && (col_q == '0);
          eol_d    = (col_q == COL_LAST);
          eof_d    = (col_q == COL_LAST) && (row_q == ROW_LAST);
          if (rd_addr_q != LAST_ADDR) begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (wr_en) begin
          err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  pixel_frame_ram #(
    .DEPTH (NPIX),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (w_ram_we),
    .re_i    (w_ram_re),
    .addr_i  (w_ram_addr),
    .wdata_i (wr_data),
    .rdata_o (Dout)
  );

  assign data_valid = valid_q;
  assign sof        = sof_q;
  assign eol        = eol_q;
  assign eof        = eof_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;
  assign wr_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_stream_tx
// Description : Directed-sequence bench for pixel_stream_tx on a 4x4 frame
//               with a frame-content model and expected marker timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_tx;

  localparam int N    = 4;
  localparam int M    = 4;
  localparam int AW   = 5;
  localparam int NPIX = N * M;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic          data_valid;
  logic [7:0]    Dout;
  logic          sof;
  logic          eol;
  logic          eof;
  logic          busy;
  logic          frame_done;
  logic [7:0]    frame_cnt;
  logic          wr_err;

  logic [7:0] model [NPIX];
  int         exp_cnt;
  int         total;
  int         bad;

  pixel_stream_tx #(
    .N  (N),
    .M  (M),
    .AW (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .data_valid (data_valid),
    .Dout       (Dout),
    .sof        (sof),
    .eol        (eol),
    .eof        (eof),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .wr_err     (wr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Host write while idle; the model only keeps in-range addresses.
  task automatic host_write(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < NPIX) model[a] = d;
  endtask

  // One complete frame starting from an idle cycle. keep leaves start high,
  // inj >= 0 injects a busy write at that pixel index, sw writes addr 0 in
  // the start cycle.
  task automatic frame(input bit keep, input int inj, input bit sw, input logic [7:0] swd);
    start = 1'b1;
    if (sw) begin
      wr_en   = 1'b1;
      wr_addr = '0;
      wr_data = swd;
    end
    tick();
    wr_en = 1'b0;
    if (sw) model[0] = swd;
    if (!keep) start = 1'b0;
    chk("prime_valid", 32'(data_valid), 0);
    chk("prime_busy", 32'(busy), 1);
    chk("prime_wr_err", 32'(wr_err), 0);
    chk("prime_dout", 32'(Dout), 0);
    tick();
    for (int k = 0; k < NPIX; k++) begin
      chk($sformatf("pix%0d_valid", k), 32'(data_valid), 1);
      chk($sformatf("pix%0d_dout", k), 32'(Dout), 32'(model[k]));
      chk($sformatf("pix%0d_sof", k), 32'(sof), 32'(k == 0));
      chk($sformatf("pix%0d_eol", k), 32'(eol), 32'((k % M) == M - 1));
      chk($sformatf("pix%0d_eof", k), 32'(eof), 32'(k == NPIX - 1));
      chk($sformatf("pix%0d_busy", k), 32'(busy), 1);
      if (k == inj) begin
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 8'hAA;
      end
      tick();
      wr_en = 1'b0;
    end
    exp_cnt = (exp_cnt + 1) % 256;
    chk("done_valid", 32'(data_valid), 0);
    chk("done_pulse", 32'(frame_done), 1);
    chk("done_cnt", 32'(frame_cnt), 32'(exp_cnt));
    chk("done_dout", 32'(Dout), 0);
    chk("done_markers", {29'd0, sof, eol, eof}, 0);
    chk("done_busy", 32'(busy), 1);
    chk("done_wr_err", 32'(wr_err), 32'(inj >= 0));
    tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(frame_done), 0);
    chk("idle_valid", 32'(data_valid), 0);
  endtask

  initial begin
    clk     = 1'b0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    exp_cnt = 0;
    total   = 0;
    bad     = 0;

    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_dout", 32'(Dout), 0);
    chk("rst_markers", {29'd0, sof, eol, eof}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_cnt", 32'(frame_cnt), 0);
    chk("rst_wr_err", 32'(wr_err), 0);
    rst_n = 1'b1;
    tick();

    // Basic frame: mem[a] = a
    for (int a = 0; a < NPIX; a++) host_write(a, 8'(a));
    frame(1'b0, -1, 1'b0, 8'h00);

    // Random frame contents
    for (int a = 0; a < NPIX; a++) host_write(a, 8'($urandom));
    frame(1'b0, -1, 1'b0, 8'h00);

    // Back-to-back frames with start held high
    for (int a = 0; a < NPIX; a++) host_write(a, 8'($urandom));
    frame(1'b1, -1, 1'b0, 8'h00);
    frame(1'b1, -1, 1'b0, 8'h00);
    frame(1'b1, -1, 1'b0, 8'h00);
    start = 1'b0;
    tick();

    // Write while busy is dropped and flagged; cleared by next start
    for (int a = 0; a < NPIX; a++) host_write(a, 8'(a));
    frame(1'b0, 6, 1'b0, 8'h00);
    chk("idle_wr_err_sticky", 32'(wr_err), 1);
    frame(1'b0, -1, 1'b0, 8'h00);

    // Simultaneous write and start
    frame(1'b0, -1, 1'b1, 8'h7E);

    // Out-of-range writes are dropped silently
    for (int i = 0; i < 4; i++) host_write(int'($urandom_range(16, 31)), 8'($urandom));
    chk("oor_wr_err", 32'(wr_err), 0);
    frame(1'b0, -1, 1'b0, 8'h00);

    // Scattered random in-range writes
    for (int i = 0; i < 8; i++) host_write(int'($urandom_range(0, NPIX - 1)), 8'($urandom));
    frame(1'b0, -1, 1'b0, 8'h00);

    // Reset mid-frame at pixel 6
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) tick();
    chk("mid_pix6_dout", 32'(Dout), 32'(model[6]));
    chk("mid_pix6_valid", 32'(data_valid), 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(data_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cnt", 32'(frame_cnt), 0);
    chk("mid_rst_dout", 32'(Dout), 0);
    chk("mid_rst_markers", {29'd0, sof, eol, eof}, 0);
    rst_n   = 1'b1;
    exp_cnt = 0;
    tick();
    tick();
    chk("mid_idle_valid", 32'(data_valid), 0);
    frame(1'b0, -1, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
